// File: rtl/lottery_ctrl_if.sv
// lottery_ctrl_if: bet-entry inputs and draw/result outputs of the lottery round controller
interface lottery_ctrl_if;
  logic start, line_done, finish, RD_ERR;
  logic [4:0] B1, B2, B3, B4;
  logic SYSRDY, res_valid, done, ovf;
  logic [4:0] D1, D2, D3, D4;
  logic [2:0] line_idx, hits;
  modport master (
    output start, line_done, finish, RD_ERR, B1, B2, B3, B4,
    input SYSRDY, res_valid, done, ovf, D1, D2, D3, D4, line_idx, hits
  );
  modport slave (
    input start, line_done, finish, RD_ERR, B1, B2, B3, B4,
    output SYSRDY, res_valid, done, ovf, D1, D2, D3, D4, line_idx, hits
  );
endinterface

// File: rtl/lottery_ctrl.sv
// lottery_ctrl: captures bet lines, draws 4 distinct LFSR numbers and scores one line per cycle
module lottery_ctrl #(
  parameter int MAX_LINES = 6,
  parameter logic [4:0] SEED = 5'b10101
) (
  input logic clk,
  input logic reset,
  lottery_ctrl_if.slave bus
);
  localparam int CW = $clog2(MAX_LINES + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_LINES);
  typedef enum logic [2:0] {IDLE, COLLECT, DRAW, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] lfsr_q, lfsr_d;
  logic [CW-1:0] cnt_q, cnt_d, ptr_q, ptr_d;
  logic [1:0] slot_q, slot_d;
  logic [3:0][4:0] d_q, d_d;
  logic [3:0][4:0] store_q [MAX_LINES];
  logic [3:0][4:0] store_d [MAX_LINES];
  logic [2:0] line_idx_q, line_idx_d, hits_q, hits_d, hit_cnt;
  logic res_valid_q, res_valid_d, done_q, done_d, ovf_q, ovf_d, dup;
  always_comb begin
    state_d = state_q;
    lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    slot_d = slot_q;
    d_d = d_q;
    store_d = store_q;
    line_idx_d = line_idx_q;
    hits_d = hits_q;
    res_valid_d = 1'b0;
    done_d = done_q;
    ovf_d = ovf_q;
    // empty slots hold 0, which the LFSR never produces, so all four can be compared
    dup = d_q[0] == lfsr_q || d_q[1] == lfsr_q || d_q[2] == lfsr_q || d_q[3] == lfsr_q;
    hit_cnt = '0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        hit_cnt = hit_cnt + 3'(store_q[ptr_q][j] == d_q[k]);
    case (state_q)
      IDLE, DONE: begin
        done_d = state_q == DONE;
        if (bus.start) begin
          state_d = COLLECT;
          cnt_d = '0;
          slot_d = '0;
          d_d = '0;
          done_d = 1'b0;
          ovf_d = 1'b0;
        end
      end
      COLLECT: begin
        if (bus.line_done && cnt_q != MAXC) begin
          store_d[cnt_q] = {bus.B4, bus.B3, bus.B2, bus.B1};
          cnt_d = cnt_q + 1'b1;
        end else if (bus.line_done) ovf_d = 1'b1;
        if (bus.finish && cnt_d != '0) state_d = DRAW;
      end
      DRAW: if (!dup) begin
        d_d[slot_q] = lfsr_q;
        slot_d = slot_q + 1'b1;
        if (slot_q == 2'd3) begin
          state_d = CHECK;
          ptr_d = '0;
        end
      end
      CHECK: begin
        line_idx_d = 3'(ptr_q);
        hits_d = hit_cnt;
        res_valid_d = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == cnt_q - 1'b1) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q <= SEED;
      cnt_q <= '0;
      ptr_q <= '0;
      slot_q <= '0;
      d_q <= '0;
      line_idx_q <= '0;
      hits_q <= '0;
      res_valid_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      slot_q <= slot_d;
      d_q <= d_d;
      line_idx_q <= line_idx_d;
      hits_q <= hits_d;
      res_valid_q <= res_valid_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) store_q <= store_d;
  assign bus.SYSRDY = state_q == COLLECT;
  assign bus.D1 = d_q[0];
  assign bus.D2 = d_q[1];
  assign bus.D3 = d_q[2];
  assign bus.D4 = d_q[3];
  assign bus.line_idx = line_idx_q;
  assign bus.hits = hits_q;
  assign bus.res_valid = res_valid_q;
  assign bus.done = done_q;
  assign bus.ovf = ovf_q;
endmodule
